// File: rtl/micro_sequencer.sv
// Control-state sequencer: selects the next microstore address and stalls on memory handshakes.
// Define MICRO_SEQ_USTACK_EN to add a one-entry call/return register with call/ret inputs.
module micro_sequencer #(
  parameter int unsigned    AW         = 8,
  parameter logic [AW-1:0]  RESET_ADDR = '0,
  parameter logic [AW-1:0]  FETCH_ADDR = AW'(1),
  parameter logic [AW-1:0]  ABORT_ADDR = '1,
  parameter int unsigned    TMO        = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] inst_addr,
  input  logic [AW-1:0] cr_addr,
  input  logic [2:0]    nsel,
  input  logic          cond_s,
  input  logic          mfa,
  input  logic          moc,
`ifdef MICRO_SEQ_USTACK_EN
  input  logic          call,
  input  logic          ret,
`endif
  output logic [AW-1:0] state,
  output logic          stall,
  output logic          mem_err
);

  typedef enum logic [0:0] {StRun, StWait} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [AW-1:0] state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [AW-1:0] inc_addr, next_addr;
  logic          take;

`ifdef MICRO_SEQ_USTACK_EN
  logic [AW-1:0] ret_q, ret_d;
`endif

  assign inc_addr = state_q + AW'(1);

  // Address selection from the sequencing field and condition result.
  always_comb begin
    next_addr = inc_addr;
    case (nsel)
      3'b000:  next_addr = inst_addr;
      3'b001:  next_addr = FETCH_ADDR;
      3'b010:  next_addr = cr_addr;
      3'b011:  next_addr = inc_addr;
      3'b100:  next_addr = cond_s ? cr_addr   : inst_addr;
      3'b101:  next_addr = cond_s ? cr_addr   : inc_addr;
      3'b110:  next_addr = cond_s ? inst_addr : inc_addr;
      default: next_addr = cond_s ? cr_addr   : FETCH_ADDR;
    endcase
`ifdef MICRO_SEQ_USTACK_EN
    if (call) begin
      next_addr = cr_addr;
    end else if (ret) begin
      next_addr = ret_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= StRun;
      state_q <= RESET_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MICRO_SEQ_USTACK_EN
      ret_q   <= RESET_ADDR;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MICRO_SEQ_USTACK_EN
      ret_q   <= ret_d;
`endif
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    take    = 1'b0;
    case (fsm_q)
      StRun: begin
        if (mfa && !moc) begin
          fsm_d = StWait;
          cnt_d = 8'd1;
        end else begin
          take = 1'b1;
        end
      end
      default: begin
        // moc beats the timeout when both land on the same cycle.
        if (moc) begin
          take  = 1'b1;
          fsm_d = StRun;
          cnt_d = '0;
        end else if (cnt_q == 8'(TMO)) begin
          state_d = ABORT_ADDR;
          err_d   = 1'b1;
          fsm_d   = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
    if (take) begin
      state_d = next_addr;
    end
  end

`ifdef MICRO_SEQ_USTACK_EN
  always_comb begin
    ret_d = ret_q;
    if (take && call) begin
      ret_d = inc_addr;
    end
  end
`endif

  always_comb begin
    stall = 1'b0;
    case (fsm_q)
      StRun:   stall = mfa && !moc;
      default: stall = 1'b1;
    endcase
  end

  assign state   = state_q;
  assign mem_err = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized and directed bench for micro_sequencer against a table-driven reference model.
// Honours MICRO_SEQ_USTACK_EN when the design is built with it.
module tb_micro_sequencer;

  localparam int unsigned TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inst_addr, cr_addr;
  logic [2:0] nsel;
  logic       cond_s, mfa, moc;
  logic       call, ret;
  logic [7:0] state;
  logic       stall, mem_err;

  int n_checks = 0;
  int n_pass   = 0;

  micro_sequencer #(
    .AW        (8),
    .RESET_ADDR(8'h00),
    .FETCH_ADDR(8'h01),
    .ABORT_ADDR(8'hFF),
    .TMO       (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inst_addr(inst_addr),
    .cr_addr  (cr_addr),
    .nsel     (nsel),
    .cond_s   (cond_s),
    .mfa      (mfa),
    .moc      (moc),
`ifdef MICRO_SEQ_USTACK_EN
    .call     (call),
    .ret      (ret),
`endif
    .state    (state),
    .stall    (stall),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  // Source index per nsel code: 0=inst_addr 1=fetch 2=cr_addr 3=state+1.
  int src_c0[8] = '{0, 1, 2, 3, 0, 3, 3, 1};
  int src_c1[8] = '{0, 1, 2, 3, 2, 2, 0, 2};

  // Reference model state.
  logic [7:0] m_state, m_ret;
  bit         m_wait, m_err;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] src[4];
    logic [7:0] r;
    src[0] = inst_addr;
    src[1] = 8'h01;
    src[2] = cr_addr;
    src[3] = m_state + 8'd1;
    r = cond_s ? src[src_c1[nsel]] : src[src_c0[nsel]];
`ifdef MICRO_SEQ_USTACK_EN
    if (call) r = cr_addr;
    else if (ret) r = m_ret;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_state = 8'h00;
    m_ret   = 8'h00;
    m_wait  = 0;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  task automatic advance();
    logic [7:0] nxt;
    nxt = pick();
`ifdef MICRO_SEQ_USTACK_EN
    if (call) m_ret = m_state + 8'd1;
`endif
    m_state = nxt;
  endtask

  task automatic model_edge();
    m_err = 0;
    if (!m_wait) begin
      if (mfa && !moc) begin
        m_wait = 1;
        m_cnt  = 1;
      end else begin
        advance();
      end
    end else if (moc) begin
      advance();
      m_wait = 0;
      m_cnt  = 0;
    end else if (m_cnt == TMO) begin
      m_state = 8'hFF;
      m_err   = 1;
      m_wait  = 0;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // Inputs must already be applied; ends 1 time unit after the clock edge.
  task automatic step(input string tag);
    #1;
    check({tag, "_stall"}, 32'(stall), 32'(m_wait || (mfa && !moc)));
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_state"}, 32'(state), 32'(m_state));
    check({tag, "_mem_err"}, 32'(mem_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    mfa = 0; moc = 0; call = 0; ret = 0; cond_s = 0;
  endtask

  task automatic go(input logic [7:0] addr);
    idle_inputs();
    nsel    = 3'b010;
    cr_addr = addr;
    step("go");
  endtask

  // Asynchronous reset asserted mid-cycle and released before the next edge.
  task automatic mid_reset(input string tag);
    #3;
    mfa   = 0;
    reset = 1;
    model_reset();
    #1;
    check({tag, "_state"}, 32'(state), 32'h00);
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_mem_err"}, 32'(mem_err), 32'h0);
    #1 reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    inst_addr = 8'h00; cr_addr = 8'h00; nsel = 3'b011;
    reset = 1;
    model_reset();
    #12;
    check("reset_state", 32'(state), 32'h00);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_err", 32'(mem_err), 32'h0);
    @(negedge clk) reset = 0;
    @(posedge clk);
    #1;

    // Reset mid-run from 0x23, then fetch.
    go(8'h23);
    check("at_23", 32'(state), 32'h23);
    mid_reset("rst_run");
    nsel = 3'b001;
    step("after_rst");
    check("after_rst_fetch", 32'(state), 32'h01);

    // Select sweep from 0x10.
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 2; c++) begin
        go(8'h10);
        inst_addr = 8'h40; cr_addr = 8'h80;
        nsel = 3'(s); cond_s = c[0];
        step("sweep");
      end
    end

    // Wrap.
    go(8'hFF);
    nsel = 3'b011;
    step("wrap");
    check("wrap_zero", 32'(state), 32'h00);

    // Handshake: moc after three stalled cycles.
    go(8'h05);
    nsel = 3'b011; mfa = 1; moc = 0;
    repeat (3) step("hs_wait");
    moc = 1;
    step("hs_rel");
    check("hs_06", 32'(state), 32'h06);
    mfa = 1; moc = 1;
    step("hs_same");
    check("hs_07", 32'(state), 32'h07);

    // Timeout after TMO counts.
    go(8'h05);
    nsel = 3'b011; mfa = 1; moc = 0;
    repeat (5) step("tmo");
    check("tmo_abort", 32'(state), 32'hFF);
    check("tmo_err", 32'(mem_err), 32'h1);
    mfa = 0;
    step("tmo_after");
    check("tmo_err_clr", 32'(mem_err), 32'h0);

    // moc arrives exactly when the counter hits TMO.
    go(8'h05);
    nsel = 3'b011; mfa = 1; moc = 0;
    repeat (4) step("tmo_edge");
    moc = 1;
    step("tmo_moc");
    check("tmo_moc_state", 32'(state), 32'h06);

    // Reset while waiting.
    go(8'h30);
    mfa = 1; moc = 0;
    repeat (2) step("rst_wait_pre");
    mid_reset("rst_wait");
    nsel = 3'b011;
    step("rst_wait_post");

`ifdef MICRO_SEQ_USTACK_EN
    go(8'h20);
    call = 1; cr_addr = 8'h60; nsel = 3'b000;
    step("call");
    check("call_60", 32'(state), 32'h60);
    call = 0; nsel = 3'b011;
    step("sub");
    ret = 1;
    step("ret");
    check("ret_21", 32'(state), 32'h21);
    call = 1; ret = 1; cr_addr = 8'h70;
    step("call_ret");
    check("call_wins", 32'(state), 32'h70);
    call = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      inst_addr = 8'($urandom);
      cr_addr   = 8'($urandom);
      nsel      = 3'($urandom);
      cond_s    = 1'($urandom);
      mfa       = ($urandom_range(0, 9) < 3);
      moc       = ($urandom_range(0, 9) < 4);
`ifdef MICRO_SEQ_USTACK_EN
      call      = ($urandom_range(0, 9) < 2);
      ret       = ($urandom_range(0, 9) < 2);
`endif
      if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
      else step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
